c2_cell_arbiter: RTL and testbench
==================================

# c2_cell_arbiter

Round-robin scheduler that shares one combinational two-input logic cell (a C2-style 4:1 multiplexer cell, truth-table configured through its four data inputs) among `N_REQ` requesters. The arbiter picks one pending requester and latches its operation code and operands. It drives the cell's truth-table and select inputs from registers, samples the cell output, then returns the result with a one-cycle completion pulse. The block sits between the requesting control logic and the single shared cell instance. It is the only driver of the cell's inputs.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `OP_W`, 2: op-code width per requester, fixed at 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  N_REQ  per-requester request level.
- `op`  in  N_REQ*2  op codes; requester i uses `op[2i+1:2i]`. 00 AND, 01 OR, 10 XOR, 11 NAND.
- `a`, `b`  in  N_REQ each  operand bits; requester i uses `a[i]`, `b[i]`.
- `gnt`  out  N_REQ  one-hot; high for the whole operation of the granted requester.
- `done`  out  N_REQ  one-hot, one-cycle completion pulse.
- `result`  out  1  operation result; valid while any `done` bit is high, held otherwise.
- `busy`  out  1  high in any state other than IDLE.
- `cell_d`  out  4  cell truth table; `cell_d[{cell_a,cell_b}]` is the selected data input (D00 = bit 0 … D11 = bit 3).
- `cell_a`, `cell_b`  out  1 each  cell select inputs.
- `cell_out`  in  1  combinational output of the shared cell.

## Operation
- FSM states: IDLE → LOAD → EVAL → RESP → IDLE. No other transitions.
- IDLE:
  - If `req` is nonzero, choose the first set bit scanning upward from `last+1`, wrapping modulo N_REQ.
  - Latch that requester's index, op, a and b. Go to LOAD.
  - If `req` is zero, stay in IDLE.
- LOAD:
  - `gnt[idx]` = 1.
  - Register `cell_d` from the latched op: AND = 4'b1000, OR = 4'b1110, XOR = 4'b0110, NAND = 4'b0111.
  - Register `cell_a` = latched a and `cell_b` = latched b.
- EVAL:
  - `gnt` held.
  - Cell inputs are stable; sample `cell_out` into `result` at the end of the cycle.
- RESP:
  - `done[idx]` = 1 and `gnt` held.
  - `last` ← idx. Return to IDLE.
- Round-robin pointer `last` resets to N_REQ-1, so requester 0 has first priority after reset.
- Operands and op are captured at arbitration. Later changes to `req`, `op`, `a` or `b` of the granted requester do not affect the operation in flight.
- If `req[idx]` drops after the grant, the operation still completes and `done[idx]` still pulses.
- If `req[idx]` is still high in the IDLE cycle after RESP, it is treated as a new request and arbitrated fairly against the others.
- Requests from non-granted requesters are not queued beyond their `req` level. They are considered at the next IDLE cycle.
- `cell_d`, `cell_a` and `cell_b` hold their last values in IDLE and RESP.

## Timing
- Reset (asynchronous, any state):
  - State goes to IDLE and `last` to N_REQ-1.
  - `gnt`, `done`, `result`, `busy`, `cell_d`, `cell_a` and `cell_b` all go to 0 immediately.
  - An in-flight operation is discarded and no `done` is issued.
- Request sampled in IDLE at edge t:
  - `gnt` and `busy` are high from t+1 through t+3.
  - `cell_*` is valid from t+2.
  - `result` is updated and `done` is high at t+3.
  - `busy` is low at t+4.
- Throughput: one operation per 4 cycles under continuous requests. Back-to-back grants have no idle gap beyond the IDLE cycle.
- Simultaneous requests: exactly one grant per IDLE cycle, chosen by round-robin. No requester waits more than N_REQ operations.
- `gnt` and `done` are never multi-hot. `done` is never high outside RESP.

## Test plan
- Reset, then `req` = 0001, op0 = OR, a0 = 1, b0 = 0 at cycle 0 → `gnt` = 0001 for cycles 1–3, `cell_d` = 4'b1110 from cycle 2, `done` = 0001 and `result` = 1 at cycle 3.
- All four ops exercised on requester 2 with all four {a,b} combinations → `result` matches AND/OR/XOR/NAND truth tables (16 checks) and `cell_d` matches the encodings above.
- `req` = 1111 held continuously → grant order 0, 1, 2, 3, 0, …, one `done` every 4 cycles, never multi-hot.
- `req[0]` held high and `req[2]` pulsed each IDLE → grants alternate 0, 2, 0, 2 (fairness).
- Operands changed and `req[1]` dropped during EVAL → `result` reflects the operands latched at grant and `done[1]` still pulses.
- `rst` asserted mid-EVAL → all outputs 0 in the same cycle, no `done`, and the next request on `req` = 1010 grants requester 1 first.

Source files
------------

// File: rtl/c2_cell_arbiter.sv
// Round-robin arbiter sharing one C2-style 4:1 mux logic cell.
// Latches the winner's op/operands, drives the cell, returns result with done.
module c2_cell_arbiter #(
  parameter int N_REQ = 4,
  parameter int OP_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*OP_W-1:0] op,
  input  logic [N_REQ-1:0]      a,
  input  logic [N_REQ-1:0]      b,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      done,
  output logic                  result,
  output logic                  busy,
  output logic [3:0]            cell_d,
  output logic                  cell_a,
  output logic                  cell_b,
  input  logic                  cell_out
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EVAL,
    RESP
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   last;
  logic [IW-1:0]   pick;
  logic            pick_ok;
  logic [OP_W-1:0] lop;
  logic            la;
  logic            lb;
  logic [N_REQ-1:0] one;

  assign one = N_REQ'(1);

  // Scan downward so the nearest set bit after last wins.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      int j;
      j = (int'(last) + k) % N_REQ;
      if (req[j]) begin
        pick    = IW'(j);
        pick_ok = 1'b1;
      end
    end
  end

  function automatic logic [3:0] enc(input logic [OP_W-1:0] o);
    logic [3:0] d;
    unique case (o)
      2'b00:   d = 4'b1000;
      2'b01:   d = 4'b1110;
      2'b10:   d = 4'b0110;
      default: d = 4'b0111;
    endcase
    return d;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      last   <= IW'(N_REQ - 1);
      idx    <= '0;
      lop    <= '0;
      la     <= 1'b0;
      lb     <= 1'b0;
      gnt    <= '0;
      done   <= '0;
      result <= 1'b0;
      busy   <= 1'b0;
      cell_d <= '0;
      cell_a <= 1'b0;
      cell_b <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_ok) begin
            idx   <= pick;
            lop   <= op[OP_W*pick +: OP_W];
            la    <= a[pick];
            lb    <= b[pick];
            gnt   <= one << pick;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          cell_d <= enc(lop);
          cell_a <= la;
          cell_b <= lb;
          state  <= EVAL;
        end
        EVAL: begin
          result <= cell_out;
          done   <= one << idx;
          state  <= RESP;
        end
        RESP: begin
          done  <= '0;
          gnt   <= '0;
          busy  <= 1'b0;
          last  <= idx;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_c2_cell_arbiter.sv
// Scoreboard bench for c2_cell_arbiter with a cycle-level reference model
// and a behavioural model of the shared mux cell.
module tb_c2_cell_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req, a, b;
  logic [2*N-1:0] op;
  logic [N-1:0] gnt, done;
  logic         result, busy;
  logic [3:0]   cell_d;
  logic         cell_a, cell_b, cell_out;

  c2_cell_arbiter #(.N_REQ(N), .OP_W(2)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .a(a), .b(b),
    .gnt(gnt), .done(done), .result(result), .busy(busy),
    .cell_d(cell_d), .cell_a(cell_a), .cell_b(cell_b),
    .cell_out(cell_out)
  );

  always #5 clk = ~clk;

  assign cell_out = cell_d[{cell_a, cell_b}];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit ref_op(input bit [1:0] o, input bit x, input bit y);
    case (o)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return !(x & y);
    endcase
  endfunction

  function automatic logic [3:0] ref_tt(input bit [1:0] o);
    case (o)
      2'd0:    return 4'b1000;
      2'd1:    return 4'b1110;
      2'd2:    return 4'b0110;
      default: return 4'b0111;
    endcase
  endfunction

  typedef struct { int idx; bit res; } exp_t;
  exp_t q[$];

  int     mph;
  int     midx;
  int     mlast;
  bit [1:0] mop;
  bit     ma, mb;

  // mph counts cycles into the current operation: 0 idle, 1..3 busy.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mph   = 0;
      mlast = N - 1;
      midx  = 0;
      q.delete();
    end else begin
      case (mph)
        0: if (req != 0) begin
          for (int k = 1; k <= N; k++) begin
            int j;
            j = (mlast + k) % N;
            if (req[j]) begin
              midx = j;
              break;
            end
          end
          mop = op[2*midx +: 2];
          ma  = a[midx];
          mb  = b[midx];
          q.push_back('{midx, ref_op(mop, ma, mb)});
          mph = 1;
        end
        1: mph = 2;
        2: mph = 3;
        default: begin
          mlast = midx;
          mph   = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] eg;
    exp_t e;
    eg = (mph != 0) ? (N'(1) << midx) : '0;
    chk("gnt", gnt, eg);
    chk("busy", busy, mph != 0);
    chk("done", done, (mph == 3) ? eg : '0);
    chk("gnt_onehot", $countones(gnt) <= 1, 1);
    if (mph == 2) begin
      chk("cell_d", cell_d, ref_tt(mop));
      chk("cell_ab", {cell_a, cell_b}, {ma, mb});
    end
    if (done != 0) begin
      if (q.size() == 0) begin
        chk("done_unexpected", done, 0);
      end else begin
        e = q.pop_front();
        chk("result", result, e.res);
        chk("done_idx", done, N'(1) << e.idx);
      end
    end
  end

  task automatic one(input int r, input bit [1:0] o, input bit x, input bit y);
    @(negedge clk);
    req = N'(1) << r;
    op[2*r +: 2] = o;
    a[r] = x;
    b[r] = y;
    @(negedge clk);
    req = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_ph(input int ph);
    int n = 0;
    while (mph != ph && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("timeout_phase", mph, ph);
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    op  = '0;
    a   = '0;
    b   = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {gnt, done, result, busy, cell_d, cell_a, cell_b}, 0);
    rst = 1'b0;

    one(0, 2'd1, 1'b1, 1'b0);

    for (int o = 0; o < 4; o++)
      for (int ab = 0; ab < 4; ab++)
        one(2, 2'(o), ab[1], ab[0]);

    @(negedge clk);
    req = 4'hF;
    repeat (40) begin
      @(negedge clk);
      op = 8'($urandom);
      a  = 4'($urandom);
      b  = 4'($urandom);
    end
    req = '0;
    repeat (5) @(negedge clk);

    req = 4'b0001;
    repeat (32) begin
      @(negedge clk);
      req[2] = (mph == 0);
    end
    req = '0;
    repeat (5) @(negedge clk);

    req = 4'b0010;
    op[3:2] = 2'd2;
    a[1] = 1'b1;
    b[1] = 1'b0;
    wait_ph(2);
    req = '0;
    op = ~op;
    a = ~a;
    b = ~b;
    repeat (5) @(negedge clk);

    req = 4'b0001;
    wait_ph(2);
    #2 rst = 1'b1;
    #1 chk("rst_mid_eval", {gnt, done, result, busy, cell_d, cell_a, cell_b}, 0);
    req = 4'b1010;
    @(negedge clk);
    rst = 1'b0;
    begin
      int n = 0;
      while (gnt == 0 && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("first_after_rst", gnt, 4'b0010);
    end
    req = '0;
    repeat (5) @(negedge clk);

    repeat (300) begin
      @(negedge clk);
      req = 4'($urandom);
      op  = 8'($urandom);
      a   = 4'($urandom);
      b   = 4'($urandom);
    end
    req = '0;
    repeat (6) @(negedge clk);
    chk("queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
